fd_inst_queue: RTL and testbench
================================

# fd_inst_queue

Instruction queue between the fetch stage and the decode stage of the pipelined MIPS CPU. Buffers fetched words so a decode stall does not discard work already fetched. Each entry carries the PC, instruction word, fetch exception code and delay-slot flag. Supports a whole-queue flush on interrupt/exception entry or `eret` redirect.

## Interface
Parameters:
- `DEPTH`, 4, number of entries; power of two, at least 2.
- `EXC_W`, 5, exception-code width; must match the `define.v` ExcCode encoding.

Ports:
- `clk`  input  1  pipeline clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-low; clears all state immediately.
- `f_valid`  input  1  fetch presents an entry this cycle.
- `f_pc`  input  32  fetch PC.
- `f_instr`  input  32  fetched word; already zeroed by fetch on AdEL.
- `f_exccode`  input  EXC_W  fetch exception code (`None` = 0, `AdEL` = 4).
- `f_isdelay`  input  1  entry is a branch delay slot.
- `f_ready`  output  1  queue can accept an entry (count < DEPTH).
- `d_valid`  output  1  head entry valid for decode.
- `d_pc`  output  32  head PC.
- `d_instr`  output  32  head instruction.
- `d_exccode`  output  EXC_W  head exception code.
- `d_isdelay`  output  1  head delay-slot flag.
- `d_ready`  input  1  decode consumes the head this cycle (not stalled).
- `flush`  input  1  discard all entries (driven by Req or D_eret).
- `count`  output  $clog2(DEPTH+1)  current occupancy.

## Operation
- Circular buffer: write pointer, read pointer (each log2(DEPTH) bits, wrapping modulo DEPTH), occupancy counter.
- Push: `f_valid && f_ready && !flush`. Stores {pc, instr, exccode, isdelay} at the write pointer; write pointer increments.
- Pop: `d_valid && d_ready && !flush`. Read pointer increments.
- Push and pop in the same cycle: count unchanged; both pointers advance.
- `f_ready` = (count != DEPTH). Registered-state derived only; it does not depend on `d_ready`. When full, a same-cycle pop does not allow a push.
- When `d_valid` = 0, `d_pc`, `d_instr`, `d_exccode` and `d_isdelay` are all 0. This makes decode see a nop with no exception.
- Entries carrying a non-zero `f_exccode` are queued and delivered unchanged. The queue does not interpret exceptions.
- Flush has priority over push and pop. Count and both pointers go to 0 at the edge. Input presented that cycle is dropped. `d_valid` is 0 from the next cycle.
- Stored payload is never cleared. Only the pointers and the count define validity.

## Timing
- Reset values: count = 0, pointers = 0, `d_valid` = 0, all `d_*` data = 0, `f_ready` = 1. These hold while reset is low and take effect asynchronously.
- Reset asserted mid-operation discards all entries at once, with no edge required.
- Base latency: an entry pushed at edge N appears on `d_*` from edge N (visible in cycle N+1).
- Sustained throughput: 1 entry/cycle when `d_ready` stays high.
- Head outputs come from the storage array through the read pointer and are stable while `d_ready` = 0.

## Configuration
- `FDQ_BYPASS_EN` defined:
  - When count = 0 and `f_valid` = 1 (no flush), `d_valid` = 1 in the same cycle and `d_*` = `f_*` combinationally.
  - If `d_ready` = 1 that cycle, the entry is consumed and not written; pointers and count are unchanged.
  - If `d_ready` = 0, the entry is written normally.
  - Latency is 0 cycles when the queue is empty.
- Not defined: no combinational path from `f_*` to `d_*`. Latency is always at least 1 cycle as described above.

## Test plan
- Reset low with `f_valid` = 1 → count = 0, `d_valid` = 0, `d_instr` = 0, `f_ready` = 1. Release reset, push PC 0x3000 instr 0x24010001 → `d_pc` = 0x3000 the next cycle (same cycle with `FDQ_BYPASS_EN`).
- `d_ready` = 0, push PCs 0x3000–0x300c (DEPTH = 4) → count = 4, `f_ready` = 0. A 5th push of 0x3010 is ignored. Set `d_ready` = 1 → outputs 0x3000, 0x3004, 0x3008, 0x300c in order.
- Pointer wrap: stream 10 entries with `d_ready` toggling 1,0,1,… → PC order preserved; count never exceeds 4 and never underflows.
- Push with `f_exccode` = 4 (AdEL), `f_instr` = 0, PC 0x2ffc → delivered as `d_exccode` = 4, `d_pc` = 0x2ffc. Next entry has `d_exccode` = 0.
- Queue holding 3 entries, `flush` = 1 with `f_valid` = 1 and `d_ready` = 1 → next cycle count = 0, `d_valid` = 0, pushed entry absent.
- Simultaneous push and pop at count = 2 → count stays 2; head advances by exactly one entry.

Source files
------------

// File: rtl/fd_inst_queue.sv
// fd_inst_queue: instruction queue between fetch and decode.
//
// Buffers fetched entries {pc, instr, exccode, isdelay} in a circular buffer
// so a decode stall does not throw away words that were already fetched.
// Fetch exception codes ride along untouched; the queue never interprets them.
//
// Handshake: an entry moves on a cycle where its valid and ready are both
// high at the rising edge. f_ready depends only on registered occupancy,
// never on d_ready. A full queue therefore refuses a push even in a cycle
// where decode pops. flush overrides both transfers that cycle.
//
// Optional feature macro: FDQ_BYPASS_EN. When it is defined and the queue is
// empty, a fetch entry is presented to decode in the same cycle. If decode
// takes it, the entry is never written. When the macro is undefined (the
// default), there is no combinational path from f_* to d_*.
//
// Ports:
//   clk        pipeline clock, rising edge
//   reset      asynchronous active-low reset
//   f_valid    fetch presents an entry
//   f_pc       fetch PC
//   f_instr    fetched word (fetch has already zeroed it on AdEL)
//   f_exccode  fetch exception code
//   f_isdelay  entry is a branch delay slot
//   f_ready    queue can accept an entry (count != DEPTH)
//   d_valid    head entry valid for decode
//   d_pc       head PC (0 when d_valid is low)
//   d_instr    head instruction (0 when d_valid is low)
//   d_exccode  head exception code (0 when d_valid is low)
//   d_isdelay  head delay-slot flag (0 when d_valid is low)
//   d_ready    decode consumes the head this cycle
//   flush      discard every entry (interrupt/exception entry or eret)
//   count      current occupancy
module fd_inst_queue #(
  parameter int DEPTH = 4,
  parameter int EXC_W = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       f_valid,
  input  logic [31:0]                f_pc,
  input  logic [31:0]                f_instr,
  input  logic [EXC_W-1:0]           f_exccode,
  input  logic                       f_isdelay,
  output logic                       f_ready,
  output logic                       d_valid,
  output logic [31:0]                d_pc,
  output logic [31:0]                d_instr,
  output logic [EXC_W-1:0]           d_exccode,
  output logic                       d_isdelay,
  input  logic                       d_ready,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  // Payload storage. It has no reset; validity comes only from the pointers
  // and the count.
  logic [31:0]      pc_mem    [DEPTH];
  logic [31:0]      instr_mem [DEPTH];
  logic [EXC_W-1:0] exc_mem   [DEPTH];
  logic             dly_mem   [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic head_valid;
  logic push;
  logic pop;

  assign head_valid = (count_q != '0);
  assign f_ready    = (count_q != CNT_W'(DEPTH));
  assign count      = count_q;

  // Pop only drains stored entries. A bypassed entry is never written, so it
  // needs no pop.
  assign pop = head_valid && d_ready && !flush;

`ifdef FDQ_BYPASS_EN
  logic bypass;
  assign bypass = !head_valid && f_valid && !flush;
  // A bypassed entry that decode takes this cycle must not be stored.
  assign push   = f_valid && f_ready && !flush && !(bypass && d_ready);

  always_comb begin
    d_valid   = head_valid || bypass;
    d_pc      = '0;
    d_instr   = '0;
    d_exccode = '0;
    d_isdelay = 1'b0;
    if (head_valid) begin
      d_pc      = pc_mem[rd_ptr_q];
      d_instr   = instr_mem[rd_ptr_q];
      d_exccode = exc_mem[rd_ptr_q];
      d_isdelay = dly_mem[rd_ptr_q];
    end else if (bypass) begin
      d_pc      = f_pc;
      d_instr   = f_instr;
      d_exccode = f_exccode;
      d_isdelay = f_isdelay;
    end
  end
`else
  assign push = f_valid && f_ready && !flush;

  // Without a valid head, decode sees an all-zero nop with no exception.
  always_comb begin
    d_valid   = head_valid;
    d_pc      = '0;
    d_instr   = '0;
    d_exccode = '0;
    d_isdelay = 1'b0;
    if (head_valid) begin
      d_pc      = pc_mem[rd_ptr_q];
      d_instr   = instr_mem[rd_ptr_q];
      d_exccode = exc_mem[rd_ptr_q];
      d_isdelay = dly_mem[rd_ptr_q];
    end
  end
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]    <= f_pc;
      instr_mem[wr_ptr_q] <= f_instr;
      exc_mem[wr_ptr_q]   <= f_exccode;
      dly_mem[wr_ptr_q]   <= f_isdelay;
    end
  end

endmodule

// File: tb/tb_fd_inst_queue.sv
module tb_fd_inst_queue;

  localparam int DEPTH = 4;
  localparam int EXC_W = 5;

  logic        clk;
  logic        reset;
  logic        f_valid;
  logic [31:0] f_pc;
  logic [31:0] f_instr;
  logic [EXC_W-1:0] f_exccode;
  logic        f_isdelay;
  logic        f_ready;
  logic        d_valid;
  logic [31:0] d_pc;
  logic [31:0] d_instr;
  logic [EXC_W-1:0] d_exccode;
  logic        d_isdelay;
  logic        d_ready;
  logic        flush;
  logic [2:0]  count;

  int vec_cnt;
  int miscompares;

  fd_inst_queue #(.DEPTH(DEPTH), .EXC_W(EXC_W)) dut (
    .clk(clk), .reset(reset),
    .f_valid(f_valid), .f_pc(f_pc), .f_instr(f_instr),
    .f_exccode(f_exccode), .f_isdelay(f_isdelay), .f_ready(f_ready),
    .d_valid(d_valid), .d_pc(d_pc), .d_instr(d_instr),
    .d_exccode(d_exccode), .d_isdelay(d_isdelay), .d_ready(d_ready),
    .flush(flush), .count(count)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge and settle.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_entry(input logic [31:0] pc, input logic [31:0] instr,
                            input logic [EXC_W-1:0] exc, input logic dly);
    f_valid   = 1'b1;
    f_pc      = pc;
    f_instr   = instr;
    f_exccode = exc;
    f_isdelay = dly;
    cyc();
  endtask

  int mcnt;
  int pushi;
  int popi;
  logic push_m;
  logic pop_m;
  logic byp_m;

  initial begin
    vec_cnt     = 0;
    miscompares = 0;
    reset     = 1'b0;
    f_valid   = 1'b1;
    f_pc      = 32'h3000;
    f_instr   = 32'h24010001;
    f_exccode = '0;
    f_isdelay = 1'b0;
    d_ready   = 1'b0;
    flush     = 1'b0;

    // Reset held low while fetch is driving.
    repeat (3) cyc();
    check_vec("rst_count",   64'(count),   64'd0);
    check_vec("rst_d_valid", 64'(d_valid), 64'd0);
    check_vec("rst_d_instr", 64'(d_instr), 64'd0);
    check_vec("rst_d_pc",    64'(d_pc),    64'd0);
    check_vec("rst_f_ready", 64'(f_ready), 64'd1);

    // First push and its latency.
    reset = 1'b1;
    #1;
`ifdef FDQ_BYPASS_EN
    check_vec("lat_pre_valid", 64'(d_valid), 64'd1);
    check_vec("lat_pre_pc",    64'(d_pc),    64'h3000);
`else
    check_vec("lat_pre_valid", 64'(d_valid), 64'd0);
    check_vec("lat_pre_pc",    64'(d_pc),    64'd0);
`endif
    cyc();
    check_vec("lat_pc",    64'(d_pc),    64'h3000);
    check_vec("lat_instr", 64'(d_instr), 64'h24010001);
    check_vec("lat_valid", 64'(d_valid), 64'd1);
    check_vec("lat_count", 64'(count),   64'd1);

    // Fill to DEPTH with decode stalled.
    push_entry(32'h3004, 32'h1, '0, 1'b0);
    push_entry(32'h3008, 32'h2, '0, 1'b0);
    push_entry(32'h300c, 32'h3, '0, 1'b0);
    check_vec("full_count",   64'(count),   64'd4);
    check_vec("full_f_ready", 64'(f_ready), 64'd0);
    push_entry(32'h3010, 32'h4, '0, 1'b0);
    check_vec("full_drop_count", 64'(count), 64'd4);
    check_vec("full_stable_pc",  64'(d_pc),  64'h3000);

    // Pop while full: the offered 0x3010 must still be refused.
    d_ready = 1'b1;
    #1;
    check_vec("drain0_pc", 64'(d_pc), 64'h3000);
    cyc();
    f_valid = 1'b0;
    check_vec("drain_count3", 64'(count), 64'd3);
    check_vec("drain1_pc", 64'(d_pc), 64'h3004);
    cyc();
    check_vec("drain2_pc", 64'(d_pc), 64'h3008);
    cyc();
    check_vec("drain3_pc", 64'(d_pc), 64'h300c);
    cyc();
    check_vec("drain_empty_valid", 64'(d_valid), 64'd0);
    check_vec("drain_empty_count", 64'(count),   64'd0);
    check_vec("drain_empty_pc",    64'(d_pc),    64'd0);

    // Pointer wrap: 10 entries, d_ready toggling 1,0,1,...
    mcnt = 0; pushi = 0; popi = 0;
    d_ready   = 1'b1;
    f_valid   = 1'b1;
    f_pc      = 32'h4000;
    f_instr   = 32'h0;
    for (int it = 0; it < 60 && popi < 10; it++) begin
      #1;
`ifdef FDQ_BYPASS_EN
      byp_m = (mcnt == 0) && f_valid;
`else
      byp_m = 1'b0;
`endif
      check_vec("wrap_f_ready", 64'(f_ready), 64'(mcnt != DEPTH));
      check_vec("wrap_d_valid", 64'(d_valid), 64'((mcnt != 0) || byp_m));
      pop_m  = d_ready && ((mcnt != 0) || byp_m);
      push_m = f_valid && (mcnt != DEPTH) && !(byp_m && d_ready);
      if (pop_m) begin
        check_vec("wrap_order_pc", 64'(d_pc), 64'(32'h4000 + 32'(popi) * 4));
        popi++;
      end
      if (push_m || (byp_m && d_ready)) pushi++;
      cyc();
      mcnt = mcnt + (push_m ? 1 : 0) - ((pop_m && !byp_m) ? 1 : 0);
      check_vec("wrap_count", 64'(count), 64'(mcnt));
      if (count > 3'(DEPTH)) check_vec("wrap_overflow", 64'(count), 64'(DEPTH));
      f_valid = (pushi < 10);
      f_pc    = 32'h4000 + 32'(pushi) * 4;
      d_ready = ~d_ready;
    end
    check_vec("wrap_all_popped", 64'(popi), 64'd10);
    f_valid = 1'b0;
    d_ready = 1'b0;
    #1;
    check_vec("wrap_end_count", 64'(count), 64'd0);

    // Exception entries pass through unchanged.
    push_entry(32'h2ffc, 32'h0, 5'd4, 1'b0);
    push_entry(32'h3000, 32'h3c011234, 5'd0, 1'b1);
    f_valid = 1'b0;
    check_vec("exc_code",  64'(d_exccode), 64'd4);
    check_vec("exc_pc",    64'(d_pc),      64'h2ffc);
    check_vec("exc_instr", 64'(d_instr),   64'd0);
    check_vec("exc_dly",   64'(d_isdelay), 64'd0);
    d_ready = 1'b1;
    cyc();
    check_vec("exc_next_code", 64'(d_exccode), 64'd0);
    check_vec("exc_next_pc",   64'(d_pc),      64'h3000);
    check_vec("exc_next_dly",  64'(d_isdelay), 64'd1);
    cyc();
    check_vec("exc_empty_valid", 64'(d_valid),   64'd0);
    check_vec("exc_empty_dly",   64'(d_isdelay), 64'd0);
    d_ready = 1'b0;

    // Flush beats push and pop.
    push_entry(32'h5000, 32'h10, '0, 1'b0);
    push_entry(32'h5004, 32'h11, '0, 1'b0);
    push_entry(32'h5008, 32'h12, '0, 1'b0);
    check_vec("flush_pre_count", 64'(count), 64'd3);
    flush   = 1'b1;
    d_ready = 1'b1;
    push_entry(32'h6000, 32'h13, '0, 1'b0);
    flush   = 1'b0;
    f_valid = 1'b0;
    #1;
    check_vec("flush_count",   64'(count),   64'd0);
    check_vec("flush_d_valid", 64'(d_valid), 64'd0);
    check_vec("flush_d_pc",    64'(d_pc),    64'd0);
    check_vec("flush_f_ready", 64'(f_ready), 64'd1);
    cyc();
    check_vec("flush_after_count", 64'(count),   64'd0);
    check_vec("flush_after_valid", 64'(d_valid), 64'd0);
    d_ready = 1'b0;

    // Simultaneous push and pop at count = 2.
    push_entry(32'h7000, 32'h20, '0, 1'b0);
    push_entry(32'h7004, 32'h21, '0, 1'b0);
    check_vec("pp_pre_count", 64'(count), 64'd2);
    d_ready = 1'b1;
    push_entry(32'h7008, 32'h22, '0, 1'b0);
    f_valid = 1'b0;
    check_vec("pp_count", 64'(count), 64'd2);
    check_vec("pp_head",  64'(d_pc),  64'h7004);
    cyc();
    check_vec("pp_head2",  64'(d_pc),  64'h7008);
    check_vec("pp_count1", 64'(count), 64'd1);
    cyc();
    check_vec("pp_count0", 64'(count), 64'd0);
    d_ready = 1'b0;

    // Asynchronous reset mid-operation, no clock edge needed.
    push_entry(32'h8000, 32'h30, '0, 1'b0);
    push_entry(32'h8004, 32'h31, '0, 1'b0);
    f_valid = 1'b0;
    check_vec("arst_pre_count", 64'(count), 64'd2);
    #2;
    reset = 1'b0;
    #1;
    check_vec("arst_count",   64'(count),   64'd0);
    check_vec("arst_d_valid", 64'(d_valid), 64'd0);
    check_vec("arst_d_pc",    64'(d_pc),    64'd0);
    check_vec("arst_f_ready", 64'(f_ready), 64'd1);
    #1;
    reset = 1'b1;
    cyc();
    check_vec("arst_post_count", 64'(count), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $finish;
  end

endmodule
